decode_stage: RTL and testbench
===============================

# decode_stage

Decode stage of the asynchronous-style RV32I pipeline, sitting directly upstream of operand fetch. Takes fetched instruction words tagged with a 4-bit branch tag, squashes wrong-path instructions, and classifies each survivor into execution unit (`xu`), operation (`instruction_type`), and immediate format (`fmts`). It also extracts the source and destination register addresses and forwards the raw word, NPC and tag for immediate extraction downstream. All outputs are registered; a hold input freezes the stage while operand fetch is locked.

## Interface
Parameters:
- `TAG_W`, default 4: width of the branch tag.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-low reset.
- `instruction`  in  32: fetched word.
- `NPC_in`  in  32: address of the fetched word.
- `tag_in`  in  TAG_W: tag attached by fetch.
- `valid_in`  in  1: `instruction` is meaningful this cycle.
- `hold`  in  1: downstream not accepting; stage retains all outputs.
- `jump_we`  in  1: retire reports a taken jump or branch.
- `jump_tag`  in  TAG_W: new current tag accompanying `jump_we`.
- `regA`, `regB`, `regD`  out  5: rs1, rs2, rd.
- `instruction_out`  out  32: registered word.
- `NPC`  out  32: registered NPC.
- `i`  out  3: `instruction_type` OP0..OP7.
- `xu_sel`  out  3: `xu` class.
- `fmt`  out  3: `fmts` class.
- `tag_out`  out  TAG_W: registered tag.
- `valid_out`  out  1: outputs hold a live instruction.
- `illegal`  out  1: present only with `DECODE_ILLEGAL_EN`.

## Operation
Tag filter:
- `cur_tag` register resets to 0.
- On a cycle with `jump_we=1`, `cur_tag` takes `jump_tag` at the clock edge.
- Comparison uses the bypassed value: `jump_we ? jump_tag : cur_tag`.
- An input is live when `valid_in=1` and `tag_in` equals the compared tag. Otherwise it is a bubble.

Bubble encoding:
- All outputs are 0, including `valid_out=0`, `regD=0` and `illegal=0`.
- With all fields 0, downstream sees a harmless write to x0.

Decode of a live word (opcode[6:2], funct3, funct7[5]):
- OP / OP-IMM: `fmt` is R (OP) or I (OP-IMM). `xu` is adder for ADD/SUB/SLT/SLTU, logical for AND/OR/XOR, shifter for SLL/SRL/SRA. `i` selects the variant.
- LUI, AUIPC: U format, adder.
- JAL: J format. JALR: I format. Both use branch.
- BRANCH: B format, branch; `i` = funct3-derived compare op.
- LOAD: I format, memory; `i` = OP0..OP4 for LB, LH, LW, LBU, LHU.
- STORE: S format, memory; `i` = OP5..OP7 for SB, SH, SW. Force `regD=0`.
- Any other opcode is illegal; see Configuration.

Field extraction:
- `regA`=[19:15], `regB`=[24:20], `regD`=[11:7].
- For U/J formats, force `regA=0`. For I/U/J formats, force `regB=0`. This avoids false lock hazards downstream.

Hold:
- While `hold=1`, every output register keeps its value and the input is ignored; fetch is responsible for re-presenting it.
- `cur_tag` still updates on `jump_we` during hold.
- A held live instruction whose tag no longer matches after a jump is converted to a bubble in place: `valid_out` is cleared and the other fields are zeroed on the next edge.

## Timing
- Latency: 1 cycle from input edge to registered outputs.
- Throughput: 1 instruction/cycle when `hold=0`.
- Reset: all outputs are 0 and `cur_tag`=0, immediately on the falling edge of `reset`.
- Simultaneous `jump_we` and `valid_in`: the new tag is used for comparison in that cycle.
- Simultaneous `hold` and `jump_we`: the tag update applies and the in-place squash rule applies; no other output changes.
- Reset during hold: reset wins.
- Tag wrap from 0xF to 0x0 is plain equality; there is no ordering between tags.

## Configuration
- `DECODE_ILLEGAL_EN` defined:
  - Adds the `illegal` port.
  - An unrecognised opcode or reserved funct3 produces `valid_out=1`, `illegal=1` and `xu_sel`=bypass, with all other class fields 0, so retire can trap.
- Undefined:
  - No `illegal` port.
  - An illegal word is emitted as a bubble (`valid_out=0`).

## Test plan
- Reset then `valid_in=1`, `tag_in=0`, ADDI x5,x1,7 (0x00708293) -> next cycle `valid_out=1`, `fmt`=I, `xu`=adder, `regA`=1, `regB`=0, `regD`=5.
- SW x2,4(x3) (0x0021A223) -> `xu`=memory, `i`=OP7, `fmt`=S, `regA`=3, `regB`=2, `regD`=0.
- `jump_we=1`, `jump_tag`=3 in the same cycle as an input with `tag_in`=0 -> bubble. The following input with `tag_in`=3 is live.
- `hold=1` for 3 cycles with changing inputs -> outputs unchanged. During the hold, `jump_we` with a mismatching tag -> `valid_out` drops to 0 on the next edge.
- Word 0xFFFFFFFF: with `DECODE_ILLEGAL_EN` -> `illegal=1`, `valid_out=1`. Without it -> `valid_out=0`.
- Assert `reset` mid-stream with `valid_out=1` -> all outputs 0 asynchronously, and `cur_tag` returns to 0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with branch-tag squash and hold, one-cycle registered outputs.
// Optional feature macro: DECODE_ILLEGAL_EN. When it is defined, the stage adds an
// `illegal` output, and unrecognised words are emitted as live trap markers with
// xu_sel=bypass. When it is undefined, unrecognised words become bubbles.
// Class encodings:
//   xu_sel : 0 none, 1 adder, 2 logical, 3 shifter, 4 branch, 5 memory, 6 bypass
//   fmt    : 0 none, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J
//   i      : adder   ADD 0, SUB 1, SLT 2, SLTU 3, LUI 4, AUIPC 5
//            logical AND 0, OR 1, XOR 2;  shifter SLL 0, SRL 1, SRA 2
//            branch  funct3 compare op, JAL 2, JALR 3
//            memory  LB 0, LH 1, LW 2, LBU 3, LHU 4, SB 5, SH 6, SW 7
module decode_stage #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic [31:0]      NPC_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             valid_in,
    input  logic             hold,
    input  logic             jump_we,
    input  logic [TAG_W-1:0] jump_tag,
    output logic [4:0]       regA,
    output logic [4:0]       regB,
    output logic [4:0]       regD,
    output logic [31:0]      instruction_out,
    output logic [31:0]      NPC,
    output logic [2:0]       i,
    output logic [2:0]       xu_sel,
    output logic [2:0]       fmt,
    output logic [TAG_W-1:0] tag_out,
    output logic             valid_out
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic             illegal
`endif
);

    localparam logic [2:0] XU_NONE   = 3'd0;
    localparam logic [2:0] XU_ADD    = 3'd1;
    localparam logic [2:0] XU_LOGIC  = 3'd2;
    localparam logic [2:0] XU_SHIFT  = 3'd3;
    localparam logic [2:0] XU_BRANCH = 3'd4;
    localparam logic [2:0] XU_MEM    = 3'd5;
`ifdef DECODE_ILLEGAL_EN
    localparam logic [2:0] XU_BYPASS = 3'd6;
`endif

    localparam logic [2:0] FMT_R = 3'd1;
    localparam logic [2:0] FMT_I = 3'd2;
    localparam logic [2:0] FMT_S = 3'd3;
    localparam logic [2:0] FMT_B = 3'd4;
    localparam logic [2:0] FMT_U = 3'd5;
    localparam logic [2:0] FMT_J = 3'd6;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    logic [TAG_W-1:0] cur_tag_q, cmp_tag;
    logic             live;
    logic [4:0]       opc;
    logic [2:0]       f3;
    logic             f7b;

    logic             dec_ok;
    logic [2:0]       dec_xu, dec_op, dec_fmt;

    logic [4:0]       rega_q, rega_d, regb_q, regb_d, regd_q, regd_d;
    logic [31:0]      instr_q, instr_d, npc_q, npc_d;
    logic [2:0]       op_q, op_d, xu_q, xu_d, fmt_q, fmt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             valid_q, valid_d;
    logic             zero_out;
`ifdef DECODE_ILLEGAL_EN
    logic             illegal_q, illegal_d;
`endif

    // A retiring jump's tag is bypassed so the same-cycle input is judged against it.
    assign cmp_tag = jump_we ? jump_tag : cur_tag_q;
    assign live    = valid_in && (tag_in == cmp_tag);
    assign opc     = instruction[6:2];
    assign f3      = instruction[14:12];
    assign f7b     = instruction[30];

    // Current branch tag; follows jump_we regardless of hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_tag_q <= '0;
        else        cur_tag_q <= cmp_tag;
    end

    // Classify the incoming word into unit, operation and immediate format.
    always_comb begin
        dec_ok  = 1'b0;
        dec_xu  = XU_NONE;
        dec_op  = 3'd0;
        dec_fmt = 3'd0;
        if (instruction[1:0] == 2'b11) begin
            case (opc)
                OPC_OP, OPC_OP_IMM: begin
                    dec_ok  = 1'b1;
                    dec_fmt = (opc == OPC_OP) ? FMT_R : FMT_I;
                    case (f3)
                        3'b000: begin dec_xu = XU_ADD;   dec_op = (opc == OPC_OP && f7b) ? 3'd1 : 3'd0; end
                        3'b001: begin dec_xu = XU_SHIFT; dec_op = 3'd0; end
                        3'b010: begin dec_xu = XU_ADD;   dec_op = 3'd2; end
                        3'b011: begin dec_xu = XU_ADD;   dec_op = 3'd3; end
                        3'b100: begin dec_xu = XU_LOGIC; dec_op = 3'd2; end
                        3'b101: begin dec_xu = XU_SHIFT; dec_op = f7b ? 3'd2 : 3'd1; end
                        3'b110: begin dec_xu = XU_LOGIC; dec_op = 3'd1; end
                        default: begin dec_xu = XU_LOGIC; dec_op = 3'd0; end
                    endcase
                end
                OPC_LUI:   begin dec_ok = 1'b1; dec_xu = XU_ADD; dec_op = 3'd4; dec_fmt = FMT_U; end
                OPC_AUIPC: begin dec_ok = 1'b1; dec_xu = XU_ADD; dec_op = 3'd5; dec_fmt = FMT_U; end
                OPC_JAL:   begin dec_ok = 1'b1; dec_xu = XU_BRANCH; dec_op = 3'd2; dec_fmt = FMT_J; end
                OPC_JALR:  begin dec_ok = (f3 == 3'b000); dec_xu = XU_BRANCH; dec_op = 3'd3; dec_fmt = FMT_I; end
                OPC_BRANCH: begin
                    dec_ok  = (f3[2:1] != 2'b01);
                    dec_xu  = XU_BRANCH;
                    dec_op  = f3;
                    dec_fmt = FMT_B;
                end
                OPC_LOAD: begin
                    dec_xu  = XU_MEM;
                    dec_fmt = FMT_I;
                    case (f3)
                        3'b000: begin dec_ok = 1'b1; dec_op = 3'd0; end
                        3'b001: begin dec_ok = 1'b1; dec_op = 3'd1; end
                        3'b010: begin dec_ok = 1'b1; dec_op = 3'd2; end
                        3'b100: begin dec_ok = 1'b1; dec_op = 3'd3; end
                        3'b101: begin dec_ok = 1'b1; dec_op = 3'd4; end
                        default: dec_ok = 1'b0;
                    endcase
                end
                OPC_STORE: begin
                    dec_ok  = (f3 <= 3'b010);
                    dec_xu  = XU_MEM;
                    dec_op  = 3'd5 + f3;
                    dec_fmt = FMT_S;
                end
                default: dec_ok = 1'b0;
            endcase
        end
    end

    // Next output state: hold keeps everything except squashing a stale-tag entry.
    always_comb begin
        rega_d   = rega_q;
        regb_d   = regb_q;
        regd_d   = regd_q;
        instr_d  = instr_q;
        npc_d    = npc_q;
        op_d     = op_q;
        xu_d     = xu_q;
        fmt_d    = fmt_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
`ifdef DECODE_ILLEGAL_EN
        illegal_d = illegal_q;
`endif
        zero_out = 1'b0;
        if (hold) begin
            zero_out = valid_q && (tag_q != cmp_tag);
        end else if (live && dec_ok) begin
            // Unused source fields are zeroed so operand fetch sees no false hazard.
            rega_d  = (dec_fmt == FMT_U || dec_fmt == FMT_J) ? 5'd0 : instruction[19:15];
            regb_d  = (dec_fmt == FMT_I || dec_fmt == FMT_U || dec_fmt == FMT_J) ? 5'd0 : instruction[24:20];
            regd_d  = (dec_fmt == FMT_S) ? 5'd0 : instruction[11:7];
            instr_d = instruction;
            npc_d   = NPC_in;
            op_d    = dec_op;
            xu_d    = dec_xu;
            fmt_d   = dec_fmt;
            tag_d   = tag_in;
            valid_d = 1'b1;
`ifdef DECODE_ILLEGAL_EN
            illegal_d = 1'b0;
        end else if (live) begin
            // Trap marker: word, NPC and tag survive for retire; register fields are x0.
            rega_d    = 5'd0;
            regb_d    = 5'd0;
            regd_d    = 5'd0;
            instr_d   = instruction;
            npc_d     = NPC_in;
            op_d      = 3'd0;
            xu_d      = XU_BYPASS;
            fmt_d     = 3'd0;
            tag_d     = tag_in;
            valid_d   = 1'b1;
            illegal_d = 1'b1;
`endif
        end else begin
            zero_out = 1'b1;
        end
        if (zero_out) begin
            rega_d  = '0;
            regb_d  = '0;
            regd_d  = '0;
            instr_d = '0;
            npc_d   = '0;
            op_d    = '0;
            xu_d    = '0;
            fmt_d   = '0;
            tag_d   = '0;
            valid_d = 1'b0;
`ifdef DECODE_ILLEGAL_EN
            illegal_d = 1'b0;
`endif
        end
    end

    // Output registers; reset clears to the bubble encoding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rega_q  <= '0;
            regb_q  <= '0;
            regd_q  <= '0;
            instr_q <= '0;
            npc_q   <= '0;
            op_q    <= '0;
            xu_q    <= '0;
            fmt_q   <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
`ifdef DECODE_ILLEGAL_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            regd_q  <= regd_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            op_q    <= op_d;
            xu_q    <= xu_d;
            fmt_q   <= fmt_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
`ifdef DECODE_ILLEGAL_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign regA            = rega_q;
    assign regB            = regb_q;
    assign regD            = regd_q;
    assign instruction_out = instr_q;
    assign NPC             = npc_q;
    assign i               = op_q;
    assign xu_sel          = xu_q;
    assign fmt             = fmt_q;
    assign tag_out         = tag_q;
    assign valid_out       = valid_q;
`ifdef DECODE_ILLEGAL_EN
    assign illegal         = illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized bench for decode_stage against a pattern-table reference model.
`timescale 1ns/1ps
module tb_decode_stage;

    localparam logic [2:0] XU_ADD = 3'd1, XU_LOG = 3'd2, XU_SHF = 3'd3;
    localparam logic [2:0] XU_BR = 3'd4, XU_MEM = 3'd5, XU_BYP = 3'd6;
    localparam logic [2:0] F_R = 3'd1, F_I = 3'd2, F_S = 3'd3, F_B = 3'd4, F_U = 3'd5, F_J = 3'd6;
    localparam logic [31:0] M_OPC = 32'h0000_007F, M_F3 = 32'h0000_707F, M_F7 = 32'h4000_707F;
`ifdef DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = '0, NPC_in = '0;
    logic [3:0]  tag_in = '0, jump_tag = '0;
    logic        valid_in = 1'b0, hold = 1'b0, jump_we = 1'b0;
    logic [4:0]  regA, regB, regD;
    logic [31:0] instruction_out, NPC;
    logic [2:0]  i, xu_sel, fmt;
    logic [3:0]  tag_out;
    logic        valid_out;
    logic        illegal_obs;

    always #5 clk = ~clk;

    decode_stage #(.TAG_W(4)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .NPC_in(NPC_in),
        .tag_in(tag_in), .valid_in(valid_in), .hold(hold), .jump_we(jump_we),
        .jump_tag(jump_tag), .regA(regA), .regB(regB), .regD(regD),
        .instruction_out(instruction_out), .NPC(NPC), .i(i), .xu_sel(xu_sel),
        .fmt(fmt), .tag_out(tag_out), .valid_out(valid_out)
`ifdef DECODE_ILLEGAL_EN
        , .illegal(illegal_obs)
`endif
    );
`ifndef DECODE_ILLEGAL_EN
    assign illegal_obs = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] mask, match;
        logic [2:0]  xu, op, fm;
    } ent_t;

    typedef struct packed {
        logic [4:0]  ra, rb, rd;
        logic [31:0] ins, npc;
        logic [2:0]  op, xu, fm;
        logic [3:0]  tag;
        logic        v, ill;
    } out_t;

    ent_t tbl [$];
    out_t exp_o;
    logic [3:0] m_tag;
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, obs, req, $time);
        end
    endtask

    task automatic add(input logic [31:0] m, input logic [31:0] mt, input logic [2:0] x,
                       input logic [2:0] o, input logic [2:0] f);
        ent_t e;
        e.mask = m; e.match = mt; e.xu = x; e.op = o; e.fm = f;
        tbl.push_back(e);
    endtask

    // Reference decode: first matching instruction pattern, then register usage by format.
    function automatic out_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input logic [3:0] t);
        out_t o;
        int hit;
        o = '0;
        hit = -1;
        foreach (tbl[k]) if (hit < 0 && (w & tbl[k].mask) == tbl[k].match) hit = k;
        if (hit >= 0) begin
            o.v = 1'b1; o.ins = w; o.npc = pc; o.tag = t;
            o.xu = tbl[hit].xu; o.op = tbl[hit].op; o.fm = tbl[hit].fm;
            o.ra = (o.fm inside {F_R, F_I, F_S, F_B}) ? w[19:15] : 5'd0;
            o.rb = (o.fm inside {F_R, F_S, F_B}) ? w[24:20] : 5'd0;
            o.rd = (o.fm != F_S) ? w[11:7] : 5'd0;
        end else if (ILL_EN) begin
            o.v = 1'b1; o.ill = 1'b1; o.xu = XU_BYP; o.ins = w; o.npc = pc; o.tag = t;
        end
        return o;
    endfunction

    task automatic check_outputs();
        chk("regA", 32'(regA), 32'(exp_o.ra));
        chk("regB", 32'(regB), 32'(exp_o.rb));
        chk("regD", 32'(regD), 32'(exp_o.rd));
        chk("instruction_out", instruction_out, exp_o.ins);
        chk("NPC", NPC, exp_o.npc);
        chk("i", 32'(i), 32'(exp_o.op));
        chk("xu_sel", 32'(xu_sel), 32'(exp_o.xu));
        chk("fmt", 32'(fmt), 32'(exp_o.fm));
        chk("tag_out", 32'(tag_out), 32'(exp_o.tag));
        chk("valid_out", 32'(valid_out), 32'(exp_o.v));
        if (ILL_EN) chk("illegal", 32'(illegal_obs), 32'(exp_o.ill));
    endtask

    // Drive one cycle from a negedge, advance the model, check at the next negedge.
    task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc, input logic [3:0] t,
                         input logic h, input logic jw, input logic [3:0] jt);
        logic [3:0] cmp;
        valid_in = v; instruction = w; NPC_in = pc; tag_in = t;
        hold = h; jump_we = jw; jump_tag = jt;
        cmp = jw ? jt : m_tag;
        if (h) begin
            if (exp_o.v && exp_o.tag != cmp) exp_o = '0;
        end else if (v && t == cmp) begin
            exp_o = ref_decode(w, pc, t);
        end else begin
            exp_o = '0;
        end
        if (jw) m_tag = jt;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    localparam logic [31:0] ADDI = 32'h0070_8293;
    localparam logic [31:0] SW   = 32'h0021_A223;

    initial begin
        add(M_F7, 32'h0000_0033, XU_ADD, 3'd0, F_R);  add(M_F7, 32'h4000_0033, XU_ADD, 3'd1, F_R);
        add(M_F3, 32'h0000_1033, XU_SHF, 3'd0, F_R);  add(M_F3, 32'h0000_2033, XU_ADD, 3'd2, F_R);
        add(M_F3, 32'h0000_3033, XU_ADD, 3'd3, F_R);  add(M_F3, 32'h0000_4033, XU_LOG, 3'd2, F_R);
        add(M_F7, 32'h0000_5033, XU_SHF, 3'd1, F_R);  add(M_F7, 32'h4000_5033, XU_SHF, 3'd2, F_R);
        add(M_F3, 32'h0000_6033, XU_LOG, 3'd1, F_R);  add(M_F3, 32'h0000_7033, XU_LOG, 3'd0, F_R);
        add(M_F3, 32'h0000_0013, XU_ADD, 3'd0, F_I);  add(M_F3, 32'h0000_2013, XU_ADD, 3'd2, F_I);
        add(M_F3, 32'h0000_3013, XU_ADD, 3'd3, F_I);  add(M_F3, 32'h0000_4013, XU_LOG, 3'd2, F_I);
        add(M_F3, 32'h0000_6013, XU_LOG, 3'd1, F_I);  add(M_F3, 32'h0000_7013, XU_LOG, 3'd0, F_I);
        add(M_F3, 32'h0000_1013, XU_SHF, 3'd0, F_I);  add(M_F7, 32'h0000_5013, XU_SHF, 3'd1, F_I);
        add(M_F7, 32'h4000_5013, XU_SHF, 3'd2, F_I);
        add(M_OPC, 32'h0000_0037, XU_ADD, 3'd4, F_U); add(M_OPC, 32'h0000_0017, XU_ADD, 3'd5, F_U);
        add(M_OPC, 32'h0000_006F, XU_BR, 3'd2, F_J);  add(M_F3, 32'h0000_0067, XU_BR, 3'd3, F_I);
        add(M_F3, 32'h0000_0063, XU_BR, 3'd0, F_B);   add(M_F3, 32'h0000_1063, XU_BR, 3'd1, F_B);
        add(M_F3, 32'h0000_4063, XU_BR, 3'd4, F_B);   add(M_F3, 32'h0000_5063, XU_BR, 3'd5, F_B);
        add(M_F3, 32'h0000_6063, XU_BR, 3'd6, F_B);   add(M_F3, 32'h0000_7063, XU_BR, 3'd7, F_B);
        add(M_F3, 32'h0000_0003, XU_MEM, 3'd0, F_I);  add(M_F3, 32'h0000_1003, XU_MEM, 3'd1, F_I);
        add(M_F3, 32'h0000_2003, XU_MEM, 3'd2, F_I);  add(M_F3, 32'h0000_4003, XU_MEM, 3'd3, F_I);
        add(M_F3, 32'h0000_5003, XU_MEM, 3'd4, F_I);
        add(M_F3, 32'h0000_0023, XU_MEM, 3'd5, F_S);  add(M_F3, 32'h0000_1023, XU_MEM, 3'd6, F_S);
        add(M_F3, 32'h0000_2023, XU_MEM, 3'd7, F_S);

        exp_o = '0;
        m_tag = 4'd0;
        @(negedge clk);
        check_outputs();
        reset = 1'b1;

        cycle(1'b1, ADDI, 32'h100, 4'd0, 1'b0, 1'b0, 4'd0);
        chk("addi_valid", 32'(valid_out), 32'd1);
        chk("addi_fmt", 32'(fmt), 32'(F_I));
        chk("addi_xu", 32'(xu_sel), 32'(XU_ADD));
        chk("addi_regA", 32'(regA), 32'd1);
        chk("addi_regB", 32'(regB), 32'd0);
        chk("addi_regD", 32'(regD), 32'd5);

        cycle(1'b1, SW, 32'h104, 4'd0, 1'b0, 1'b0, 4'd0);
        chk("sw_xu", 32'(xu_sel), 32'(XU_MEM));
        chk("sw_i", 32'(i), 32'd7);
        chk("sw_fmt", 32'(fmt), 32'(F_S));
        chk("sw_regA", 32'(regA), 32'd3);
        chk("sw_regB", 32'(regB), 32'd2);
        chk("sw_regD", 32'(regD), 32'd0);

        cycle(1'b1, ADDI, 32'h108, 4'd0, 1'b0, 1'b1, 4'd3);
        chk("jump_bubble", 32'(valid_out), 32'd0);
        cycle(1'b1, ADDI, 32'h200, 4'd3, 1'b0, 1'b0, 4'd0);
        chk("newtag_live", 32'(valid_out), 32'd1);

        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, $urandom, $urandom, 4'd3, 1'b1, 1'b0, 4'd0);
            chk("hold_valid", 32'(valid_out), 32'd1);
            chk("hold_npc", NPC, 32'h200);
            chk("hold_word", instruction_out, ADDI);
        end
        cycle(1'b1, SW, 32'h300, 4'd3, 1'b1, 1'b1, 4'd6);
        chk("hold_squash_valid", 32'(valid_out), 32'd0);
        chk("hold_squash_word", instruction_out, 32'd0);

        cycle(1'b1, 32'hFFFF_FFFF, 32'h400, 4'd6, 1'b0, 1'b0, 4'd0);
        chk("ffff_valid", 32'(valid_out), 32'(ILL_EN));
        if (ILL_EN) begin
            chk("ffff_illegal", 32'(illegal_obs), 32'd1);
            chk("ffff_xu", 32'(xu_sel), 32'(XU_BYP));
        end

        for (int n = 0; n < 1500; n++) begin
            logic jw, h, v;
            logic [3:0] jt, t, cmp;
            logic [31:0] w;
            int k;
            jw  = ($urandom_range(0, 9) == 0);
            jt  = 4'($urandom);
            h   = ($urandom_range(0, 4) == 0);
            v   = ($urandom_range(0, 4) != 0);
            cmp = jw ? jt : m_tag;
            t   = ($urandom_range(0, 3) != 0) ? cmp : 4'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, tbl.size() - 1);
                w = ($urandom & ~tbl[k].mask) | tbl[k].match;
            end else begin
                w = $urandom;
            end
            cycle(v, w, $urandom, t, h, jw, jt);
        end

        cycle(1'b1, ADDI, 32'h500, 4'd9, 1'b0, 1'b1, 4'd9);
        chk("pre_reset_valid", 32'(valid_out), 32'd1);
        hold = 1'b1;
        #2 reset = 1'b0;
        #1;
        exp_o = '0;
        m_tag = 4'd0;
        check_outputs();
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
        cycle(1'b1, ADDI, 32'h600, 4'd0, 1'b0, 1'b0, 4'd0);
        chk("tag_after_reset", 32'(valid_out), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
